// File: rtl/uart_sensor_report.sv
// Multi-channel sensor reporter: formats per-channel BCD readings,
// thresholds and alarm flags into ASCII lines on a byte stream, and parses
// two-byte threshold commands from the UART receiver.
//
// Frame FSM
//   state   | meaning
//   IDLE    | waiting for a pending report request
//   LOAD    | one cycle, snapshot readings, thresholds and alarms
//   SEND    | presenting report bytes, advancing on each acceptance
//
// Command parser
//   state   | meaning
//   PS_OP   | expecting '+', '-' or 'R'
//   PS_CH   | expecting the channel digit for the stored op
module uart_sensor_report #(
  parameter int CLK_FRE   = 50,
  parameter int REPORT_MS = 1000,
  parameter int CH_NUM    = 2,
  parameter int THR_INIT  = 40,
  parameter int HYST      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_NUM*16-1:0]  sensor_data,
  output logic [CH_NUM-1:0]     alarm,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  frame_busy
);

  localparam longint PERIOD = longint'(REPORT_MS) * longint'(CLK_FRE) * 64'sd1000;
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_NUM - 1);
  localparam logic [7:0]       CH_CHAR_LAST = 8'(8'h30 + CH_NUM - 1);
  localparam logic [6:0]       THR_RST = 7'(THR_INIT);
  localparam logic [6:0]       HYST_V  = 7'(HYST);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam logic [0:0] PS_OP = 1'b0;
  localparam logic [0:0] PS_CH = 1'b1;

  logic [CNT_W-1:0]     per_cnt;
  logic                 per_tick;
  logic                 pending;
  logic                 frame_start;

  logic [0:0]           ps_state;
  logic                 ps_inc;
  logic                 cmd_report;
  logic                 ch_hit;
  logic [CH_W-1:0]      cmd_ch;

  logic [6:0]           thr      [CH_NUM];
  logic [6:0]           snap_thr [CH_NUM];
  logic [CH_NUM*16-1:0] snap_data;
  logic [CH_NUM-1:0]    snap_alarm;
  logic [CH_NUM-1:0]    al_set;
  logic [CH_NUM-1:0]    al_clr;

  logic [1:0]           state;
  logic [CH_W-1:0]      ch_idx;
  logic [3:0]           byte_idx;
  logic [15:0]          cur_val;
  logic [6:0]           cur_thr;
  logic                 cur_alarm;
  logic [7:0]           fmt_byte;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  function automatic logic digits_ok(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9);
  endfunction

  function automatic logic [6:0] int_part(input logic [15:0] v);
    return 7'(v[15:12]) * 7'd10 + 7'(v[11:8]);
  endfunction

  assign per_tick    = (per_cnt == CNT_LAST);
  assign frame_start = (state == ST_IDLE) && pending;

  // Free-running report period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) per_cnt <= '0;
    else if (per_tick) per_cnt <= '0;
    else per_cnt <= per_cnt + CNT_W'(1);
  end

  // Report request latch; a new request in the frame-start cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= 1'b0;
    else if (per_tick || cmd_report) pending <= 1'b1;
    else if (frame_start) pending <= 1'b0;
  end

  // Decode the current received byte against the parser state.
  always_comb begin
    cmd_report = rx_valid && (ps_state == PS_OP) && (rx_data == 8'h52);
    ch_hit     = rx_valid && (ps_state == PS_CH) &&
                 (rx_data >= 8'h30) && (rx_data <= CH_CHAR_LAST);
    cmd_ch     = CH_W'(rx_data - 8'h30);
  end

  // Two-byte command parser: op byte, then channel digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_state <= PS_OP;
      ps_inc   <= 1'b0;
    end else if (rx_valid) begin
      if (ps_state == PS_OP) begin
        if (rx_data == 8'h2B) begin
          ps_inc   <= 1'b1;
          ps_state <= PS_CH;
        end else if (rx_data == 8'h2D) begin
          ps_inc   <= 1'b0;
          ps_state <= PS_CH;
        end
      end else begin
        ps_state <= PS_OP;
      end
    end
  end

  // Per-channel thresholds, saturating at 0 and 99.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH_NUM; k++) thr[k] <= THR_RST;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (ch_hit && (cmd_ch == CH_W'(k))) begin
          if (ps_inc) begin
            if (thr[k] < 7'd99) thr[k] <= thr[k] + 7'd1;
          end else begin
            if (thr[k] != 7'd0) thr[k] <= thr[k] - 7'd1;
          end
        end
      end
    end
  end

  // Alarm set/clear conditions from live readings; invalid digits hold.
  always_comb begin
    al_set = '0;
    al_clr = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (digits_ok(sensor_data[k*16 +: 16])) begin
        al_set[k] = int_part(sensor_data[k*16 +: 16]) >= thr[k];
        al_clr[k] = (thr[k] > HYST_V) &&
                    (int_part(sensor_data[k*16 +: 16]) < (thr[k] - HYST_V));
      end
    end
  end

  // Alarm register with hysteresis.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarm <= '0;
    else alarm <= al_set | (alarm & ~al_clr);
  end

  // Frame sequencing: channel and byte counters walk the report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ch_idx   <= '0;
      byte_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending) state <= ST_LOAD;
        end
        ST_LOAD: begin
          state    <= ST_SEND;
          ch_idx   <= '0;
          byte_idx <= '0;
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (byte_idx == 4'd15) begin
              byte_idx <= '0;
              if (ch_idx == CH_LAST) state <= ST_IDLE;
              else ch_idx <= ch_idx + CH_W'(1);
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Snapshot taken in LOAD so the whole frame reports one instant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_data  <= '0;
      snap_alarm <= '0;
      for (int k = 0; k < CH_NUM; k++) snap_thr[k] <= THR_RST;
    end else if (state == ST_LOAD) begin
      snap_data  <= sensor_data;
      snap_alarm <= alarm;
      for (int k = 0; k < CH_NUM; k++) snap_thr[k] <= thr[k];
    end
  end

  // Select the snapshot fields of the channel being sent.
  always_comb begin
    cur_val   = '0;
    cur_thr   = '0;
    cur_alarm = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (ch_idx == CH_W'(k)) begin
        cur_val   = snap_data[k*16 +: 16];
        cur_thr   = snap_thr[k];
        cur_alarm = snap_alarm[k];
      end
    end
  end

  // Line layout: "Ck:dd.dd Ttt A\r\n".
  always_comb begin
    fmt_byte = 8'h0A;
    case (byte_idx)
      4'd0:    fmt_byte = 8'h43;
      4'd1:    fmt_byte = 8'h30 + 8'(ch_idx);
      4'd2:    fmt_byte = 8'h3A;
      4'd3:    fmt_byte = digit_char(cur_val[15:12]);
      4'd4:    fmt_byte = digit_char(cur_val[11:8]);
      4'd5:    fmt_byte = 8'h2E;
      4'd6:    fmt_byte = digit_char(cur_val[7:4]);
      4'd7:    fmt_byte = digit_char(cur_val[3:0]);
      4'd8:    fmt_byte = 8'h20;
      4'd9:    fmt_byte = 8'h54;
      4'd10:   fmt_byte = 8'h30 + 8'(cur_thr / 7'd10);
      4'd11:   fmt_byte = 8'h30 + 8'(cur_thr % 7'd10);
      4'd12:   fmt_byte = 8'h20;
      4'd13:   fmt_byte = cur_alarm ? 8'h41 : 8'h2D;
      4'd14:   fmt_byte = 8'h0D;
      default: fmt_byte = 8'h0A;
    endcase
  end

  assign tx_valid   = (state == ST_SEND);
  assign frame_busy = (state != ST_IDLE);
  assign tx_data    = tx_valid ? fmt_byte : 8'h00;

endmodule

// File: tb/tb_uart_sensor_report.sv
module tb_uart_sensor_report;

  localparam int CH_NUM   = 2;
  localparam int THR_INIT = 40;
  localparam int HYST     = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [CH_NUM*16-1:0] sensor_data = '0;
  logic [CH_NUM-1:0]    alarm;
  logic                 tx_valid;
  logic                 tx_ready = 1'b1;
  logic [7:0]           tx_data;
  logic                 rx_valid = 1'b0;
  logic [7:0]           rx_data = 8'h00;
  logic                 frame_busy;

  uart_sensor_report #(
    .CLK_FRE(1), .REPORT_MS(1), .CH_NUM(CH_NUM), .THR_INIT(THR_INIT), .HYST(HYST)
  ) dut (
    .clk(clk), .rst(rst), .sensor_data(sensor_data), .alarm(alarm),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .frame_busy(frame_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: thresholds, alarms and parser kept as plain integers.
  int         m_thr [CH_NUM];
  logic [CH_NUM-1:0] m_alarm;
  logic [7:0] m_op;
  int         md3, md2, mval, mb, mch;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_thr[k]) m_thr[k] = THR_INIT;
      m_alarm = '0;
      m_op = 8'h00;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        md3 = int'(sensor_data[k*16+12 +: 4]);
        md2 = int'(sensor_data[k*16+8 +: 4]);
        if (md3 < 10 && md2 < 10) begin
          mval = md3 * 10 + md2;
          if (mval >= m_thr[k]) m_alarm[k] = 1'b1;
          else if (mval < m_thr[k] - HYST) m_alarm[k] = 1'b0;
        end
      end
      if (rx_valid) begin
        mb = int'(rx_data);
        if (m_op != 8'h00) begin
          mch = mb - 48;
          if (mch >= 0 && mch < CH_NUM) begin
            if (m_op == 8'h2B) m_thr[mch] = (m_thr[mch] >= 99) ? 99 : m_thr[mch] + 1;
            else m_thr[mch] = (m_thr[mch] <= 0) ? 0 : m_thr[mch] - 1;
          end
          m_op = 8'h00;
        end else if (mb == 43 || mb == 45) begin
          m_op = rx_data;
        end
      end
    end
  end

  // Scoreboard and stream-protocol monitor, sampled on the falling edge.
  logic [7:0] exp_q[$];
  logic [7:0] cur_frame[$];
  logic [7:0] last_frame[$];
  int         load_q[$];
  int         frames_done = 0;
  int         nbytes = 0;
  int         cyc = 0;
  bit         prev_busy = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dch(input logic [3:0] d);
    return (d <= 4'd9) ? 8'(48 + int'(d)) : 8'h3F;
  endfunction

  task automatic push_frame();
    logic [15:0] v;
    for (int k = 0; k < CH_NUM; k++) begin
      v = sensor_data[k*16 +: 16];
      exp_q.push_back(8'h43);
      exp_q.push_back(8'(48 + k));
      exp_q.push_back(8'h3A);
      exp_q.push_back(dch(v[15:12]));
      exp_q.push_back(dch(v[11:8]));
      exp_q.push_back(8'h2E);
      exp_q.push_back(dch(v[7:4]));
      exp_q.push_back(dch(v[3:0]));
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h54);
      exp_q.push_back(8'(48 + m_thr[k] / 10));
      exp_q.push_back(8'(48 + m_thr[k] % 10));
      exp_q.push_back(8'h20);
      exp_q.push_back(m_alarm[k] ? 8'h41 : 8'h2D);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      load_q.delete();
      prev_busy = 0;
      prev_stall = 0;
      nbytes = 0;
    end else begin
      chk("alarm_vs_model", alarm, m_alarm);
      if (tx_valid) chk("busy_while_valid", frame_busy, 1'b1);
      if (frame_busy && !prev_busy) begin
        chk("no_leftover_bytes_at_load", exp_q.size(), 0);
        exp_q.delete();
        push_frame();
        load_q.push_back(cyc);
        nbytes = 0;
        cur_frame.delete();
      end
      if (prev_stall) begin
        chk("stall_valid_held", tx_valid, 1'b1);
        chk("stall_data_held", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        chk("byte_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) chk($sformatf("tx_byte_%0d", nbytes), tx_data, exp_q.pop_front());
        cur_frame.push_back(tx_data);
        nbytes++;
      end
      if (!frame_busy && prev_busy) begin
        chk("frame_length", nbytes, 32);
        frames_done++;
        last_frame = cur_frame;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_busy  = frame_busy;
    end
  end

  bit rnd_ready = 0;
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] ch, input int times);
    for (int i = 0; i < times; i++) begin
      send_rx(op);
      send_rx(ch);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (frame_busy && n < budget) begin tick(1); n++; end
    chk("wait_idle_bound", frame_busy, 1'b0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin tick(1); n++; end
    chk("wait_frame_bound", frames_done >= target, 1'b1);
  endtask

  task automatic report();
    int t;
    wait_idle(400);
    t = frames_done;
    send_rx(8'h52);
    wait_frames(t + 1, 600);
    wait_idle(400);
  endtask

  task automatic chk_line(input int base, input string s);
    chk("last_frame_size", last_frame.size(), 32);
    if (last_frame.size() == 32) begin
      for (int i = 0; i < 14; i++)
        chk($sformatf("line%0d_char%0d", base / 16, i), last_frame[base + i], 8'(s[i]));
      chk($sformatf("line%0d_cr", base / 16), last_frame[base + 14], 8'h0D);
      chk($sformatf("line%0d_lf", base / 16), last_frame[base + 15], 8'h0A);
    end
  endtask

  function automatic logic [15:0] rand_reading();
    logic [15:0] v;
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    return v;
  endfunction

  int rel;
  int n;
  bit saw_out;
  logic [7:0] rb;

  initial begin
    // Reset values
    tick(3);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_frame_busy", frame_busy, 1'b0);
    chk("rst_alarm", alarm, 2'b00);
    @(negedge clk);
    #1 rst = 1'b0;
    tick(1);

    // Basic frame with constant ready
    sensor_data = {16'h4120, 16'h2534};
    tick(2);
    chk("alarm_basic", alarm, 2'b10);
    report();
    chk_line(0, "C0:25.34 T40 -");
    chk_line(16, "C1:41.20 T40 A");

    // Same frame under back-pressure
    rnd_ready = 1;
    report();
    rnd_ready = 0;
    chk_line(0, "C0:25.34 T40 -");
    chk_line(16, "C1:41.20 T40 A");

    // Threshold commands and hysteresis
    send_cmd(8'h2B, 8'h31, 3);
    send_cmd(8'h2D, 8'h30, 1);
    tick(2);
    chk("alarm_after_thr_change", alarm, 2'b10);
    report();
    chk_line(0, "C0:25.34 T39 -");
    chk_line(16, "C1:41.20 T43 A");
    sensor_data[31:16] = 16'h4199;
    tick(2);
    chk("alarm1_hold_41", alarm[1], 1'b1);
    sensor_data[31:16] = 16'h4000;
    tick(2);
    chk("alarm1_clear_40", alarm[1], 1'b0);
    sensor_data[31:16] = 16'h4120;
    tick(2);
    chk("alarm1_no_reset_41", alarm, 2'b00);

    // Malformed commands leave thresholds alone
    send_rx(8'h2B); send_rx(8'h35);
    send_rx(8'h58);
    send_rx(8'h2D); send_rx(8'h5A);
    report();
    chk_line(0, "C0:25.34 T39 -");
    chk_line(16, "C1:41.20 T43 -");

    // Saturation at both ends
    send_cmd(8'h2D, 8'h30, 50);
    tick(2);
    chk("alarm0_thr_zero", alarm[0], 1'b1);
    report();
    chk_line(0, "C0:25.34 T00 A");
    send_cmd(8'h2B, 8'h30, 120);
    tick(2);
    chk("alarm0_thr_99", alarm[0], 1'b0);

    // Non-decimal digit renders as '?', alarm holds
    sensor_data[15:0] = 16'hA534;
    tick(2);
    chk("alarm0_invalid_hold", alarm[0], 1'b0);
    report();
    chk("question_mark_byte", last_frame.size() == 32 ? last_frame[3] : 8'hxx, 8'h3F);
    chk_line(0, "C0:?5.34 T99 -");

    // Randomized commands, readings and back-pressure
    rnd_ready = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0)
        sensor_data = {rand_reading(), rand_reading()};
      case ($urandom_range(0, 9))
        0, 7:    rb = 8'h2B;
        1, 8:    rb = 8'h2D;
        2:       rb = 8'h52;
        3, 9:    rb = 8'h30;
        4:       rb = 8'h31;
        5:       rb = 8'h32;
        default: rb = 8'h58;
      endcase
      send_rx(rb);
    end
    rnd_ready = 0;
    wait_idle(400);

    // Reset during byte 7 of a frame
    sensor_data = {16'h4120, 16'h2534};
    send_rx(8'h52);
    n = 0;
    while (!(frame_busy && nbytes == 7) && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_byte7", frame_busy && nbytes == 7, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", tx_valid, 1'b0);
    chk("async_rst_busy", frame_busy, 1'b0);
    chk("async_rst_tx_data", tx_data, 8'h00);
    chk("async_rst_alarm", alarm, 2'b00);
    @(negedge clk);
    #1 rst = 1'b0;
    rel = cyc;
    saw_out = 0;
    for (int i = 0; i < 900; i++) begin
      tick(1);
      if (frame_busy || tx_valid) saw_out = 1;
    end
    chk("quiet_after_reset", saw_out, 1'b0);

    // Periodic timing and coalesced request during a frame
    n = 0;
    while (load_q.size() < 1 && n < 300) begin tick(1); n++; end
    chk("timer_frame_seen", load_q.size() >= 1, 1'b1);
    if (load_q.size() >= 1) chk("first_timer_load_cycle", load_q[0] - rel, 1001);
    n = 0;
    while (nbytes < 5 && n < 100) begin tick(1); n++; end
    send_rx(8'h52);
    send_rx(8'h52);
    n = 0;
    while (load_q.size() < 2 && n < 200) begin tick(1); n++; end
    chk("extra_frame_seen", load_q.size() >= 2, 1'b1);
    if (load_q.size() >= 2) chk("extra_frame_gap", load_q[1] - load_q[0], 34);
    chk_line(0, "C0:25.34 T40 -");
    chk_line(16, "C1:41.20 T40 A");
    while (cyc - rel < 1900) tick(1);
    chk("single_extra_frame", load_q.size(), 2);
    n = 0;
    while (load_q.size() < 3 && n < 300) begin tick(1); n++; end
    chk("second_timer_seen", load_q.size() >= 3, 1'b1);
    if (load_q.size() >= 3) chk("second_timer_load_cycle", load_q[2] - rel, 2001);
    wait_idle(400);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
